tm1638_responder: RTL and testbench
===================================

Name: tm1638_responder

Overview:
- Device-side (chip-end) emulation of the TM1638 LED&KEY serial interface. It is the counterpart of the ledandkey host driver.
- Receives STB/CLK/DIO from a host, decodes the three TM1638 command types, holds the 16-byte display RAM and display control, and returns 4 key-scan bytes on DIO during read frames.
- Used as a synthesizable loopback target for verifying ledandkey, and as a board emulator for students without hardware.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on each of tm_strobe, tm_clock and tm_dio_in (minimum 2).

Ports:
- clock  input  1  system clock; all logic is in this domain.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- tm_strobe  input  1  host STB; active low, frames a transaction.
- tm_clock  input  1  host CLK; sample on rising edge, drive on falling edge.
- tm_dio_in  input  1  DIO pad input.
- tm_dio_out  output  1  DIO value when driving.
- tm_dio_oe  output  1  1 = responder drives DIO; the top-level tristate is built from this.
- keys_in  input  32  key-scan image; byte k = keys_in[8k+7:8k].
- disp_ram  output  128  display RAM; address a = disp_ram[8a+7:8a].
- display_on  output  1  display enable from the display control command.
- brightness  output  3  pulse-width setting from the display control command.
- frame_done  output  1  one-cycle pulse on each STB rising edge.
- proto_error  output  1  one-cycle pulse when a partial byte is discarded at STB rise.

Behaviour:
- Reset (while reset==0), all outputs and state cleared:
  - disp_ram=0, display_on=0, brightness=0, tm_dio_out=1, tm_dio_oe=0, pulses=0.
  - Mode: write, auto-increment. Address=0. FSM=IDLE.
- Input handling:
  - Inputs pass through SYNC_STAGES flops, then one edge-detect register. Inputs idle high at reset.
  - An edge is acted on SYNC_STAGES+1 clocks after the pin changes.
- Framing and bits:
  - Synchronized STB falling edge starts a frame; bit counter=0.
  - Bits are shifted in LSB first on each CLK rising edge while STB=0.
- FSM states: IDLE, CMD, WDATA, RDATA, IGNORE.
- IDLE -> CMD on STB fall.
- CMD: the 8th bit completes the command byte; decode on the same cycle as the 8th edge is detected.
  - 01xx_xfr0 (data command): f=1 selects fixed address, f=0 auto-increment. r=0 -> IGNORE (remaining bytes ignored). r=1 -> RDATA; keys_in is snapshotted into the read shift register on this cycle.
  - 11xx_aaaa (address command): address=aaaa -> WDATA.
  - 10xx_dbbb (display control): display_on=d, brightness=bbb -> IGNORE.
  - 00xx_xxxx: no effect -> IGNORE.
- WDATA: each completed byte is written to disp_ram[address] the cycle its 8th edge is detected.
  - Auto-increment mode: address increments modulo 16 (15 wraps to 0).
  - Fixed mode: address is held.
- RDATA:
  - On each CLK falling edge: tm_dio_oe=1 and tm_dio_out = next snapshot bit, byte0 LSB first.
  - After 32 bits are shifted out, tm_dio_oe=0 on the 33rd falling edge. Further clocks are ignored.
- STB rise (any state): FSM -> IDLE, tm_dio_oe=0 and tm_dio_out=1 on the same cycle, frame_done=1 for 1 cycle.
  - If the bit counter is nonzero and the state is CMD or WDATA, the partial byte is discarded and proto_error=1 for 1 cycle.
- Mode and address persist across frames. Only a data command changes mode; only an address command changes address.
- A CLK edge coinciding with the STB rise in the same synchronized cycle: STB wins and the bit is dropped.
- Async reset assertion mid-frame: immediate return to reset values, including tm_dio_oe=0. After release, wait for a fresh STB fall.

Decomposition:
- Package tm1638_pkg:
  - State enum: IDLE, CMD, WDATA, RDATA, IGNORE.
  - Command type field values: 2'b01 data, 2'b10 display, 2'b11 address.
  - Bit positions for fixed-address, read and display-on flags.
  - Constants NUM_GRIDS=16 and KEY_BYTES=4.
- One sub-module, tm1638_sync_edge: SYNC_STAGES synchronizer plus rise/fall pulse outputs, instantiated three times.

Test Plan:
- Reset mid-frame: drop reset during a WDATA byte -> all outputs return to reset values at once; next frame 0xC0,0x3F writes disp_ram[7:0]=0x3F.
- Auto-increment write: frame 0x40; frame 0xC0,0x3F,0x06,0x77 -> addresses 0,1,2 = 0x3F,0x06,0x77. Frame 0xCF,0x11,0x22 -> addr15=0x11, addr0=0x22 (wrap).
- Fixed address: frame 0x44; frame 0xC5,0xAA,0xBB -> addr5=0xBB, addr6 unchanged.
- Display control: frame 0x8F -> display_on=1, brightness=7. Frame 0x80 -> display_on=0, brightness=0. frame_done pulses once per frame.
- Key read: keys_in=0x04_10_40_01, frame 0x42 plus 32 clocks -> host samples bytes 0x01,0x40,0x10,0x04 (LSB first); tm_dio_oe=0 after the 32nd bit and at STB rise.
- Partial byte: STB rises after 5 bits of a WDATA byte -> proto_error pulses once, disp_ram unchanged, address unchanged.

Source files
------------

// File: rtl/tm1638_pkg.sv
// Shared types and constants for the TM1638 device-side responder.
package tm1638_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA,
        RDATA,
        IGNORE
    } state_t;

    // Command type lives in the top two bits of the first byte of a frame.
    typedef enum logic [1:0] {
        CMD_NONE    = 2'b00,
        CMD_DATA    = 2'b01,
        CMD_DISPLAY = 2'b10,
        CMD_ADDR    = 2'b11
    } cmd_type_t;

    localparam int unsigned FIXED_BIT   = 2;
    localparam int unsigned READ_BIT    = 1;
    localparam int unsigned DISP_ON_BIT = 3;

    localparam int unsigned NUM_GRIDS = 16;
    localparam int unsigned KEY_BYTES = 4;

endpackage

// File: rtl/tm1638_sync_edge.sv
// Multi-flop synchronizer for one host pin with registered-edge rise/fall pulses.
module tm1638_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    // Pins idle high, so reset to 1 to avoid a spurious edge after release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync <= '1;
            prev <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign level = sync[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/tm1638_responder.sv
// TM1638 chip-end emulation: decodes host frames into display RAM/control and
// returns the key-scan image on DIO during read frames.
module tm1638_responder
    import tm1638_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   tm_strobe,
    input  logic                   tm_clock,
    input  logic                   tm_dio_in,
    output logic                   tm_dio_out,
    output logic                   tm_dio_oe,
    input  logic [KEY_BYTES*8-1:0] keys_in,
    output logic [NUM_GRIDS*8-1:0] disp_ram,
    output logic                   display_on,
    output logic [2:0]             brightness,
    output logic                   frame_done,
    output logic                   proto_error
);

    logic stb_level, stb_rise, stb_fall;
    logic clk_level, clk_rise, clk_fall;
    logic dio_level, dio_rise, dio_fall;
    logic [2:0] unused_edges;

    tm1638_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_stb (
        .clock(clock), .reset(reset), .pin(tm_strobe),
        .level(stb_level), .rise(stb_rise), .fall(stb_fall)
    );
    tm1638_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clock(clock), .reset(reset), .pin(tm_clock),
        .level(clk_level), .rise(clk_rise), .fall(clk_fall)
    );
    tm1638_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dio (
        .clock(clock), .reset(reset), .pin(tm_dio_in),
        .level(dio_level), .rise(dio_rise), .fall(dio_fall)
    );
    assign unused_edges = {clk_level, dio_rise, dio_fall};

    state_t                 state, state_n;
    logic [2:0]             bit_cnt, bit_cnt_n;
    logic [7:0]             shift, shift_n;
    logic [3:0]             addr, addr_n;
    logic                   fixed, fixed_n;
    logic [NUM_GRIDS*8-1:0] disp_ram_n;
    logic                   display_on_n;
    logic [2:0]             brightness_n;
    logic [KEY_BYTES*8-1:0] rd_shift, rd_shift_n;
    logic [5:0]             rd_cnt, rd_cnt_n;
    logic                   dio_out_n, dio_oe_n;
    logic                   frame_done_n, proto_error_n;
    logic [7:0]             new_byte;
    logic                   bit_edge, drive_edge;

    // LSB first: each new bit enters at the top, so after 8 bits bit 0 is the first one.
    assign new_byte   = {dio_level, shift[7:1]};
    assign bit_edge   = clk_rise & ~stb_level;
    assign drive_edge = clk_fall & ~stb_level;

    always_comb begin
        state_n       = state;
        bit_cnt_n     = bit_cnt;
        shift_n       = shift;
        addr_n        = addr;
        fixed_n       = fixed;
        disp_ram_n    = disp_ram;
        display_on_n  = display_on;
        brightness_n  = brightness;
        rd_shift_n    = rd_shift;
        rd_cnt_n      = rd_cnt;
        dio_out_n     = tm_dio_out;
        dio_oe_n      = tm_dio_oe;
        frame_done_n  = 1'b0;
        proto_error_n = 1'b0;

        if (stb_rise) begin
            state_n      = IDLE;
            bit_cnt_n    = '0;
            dio_oe_n     = 1'b0;
            dio_out_n    = 1'b1;
            frame_done_n = 1'b1;
            if (bit_cnt != 3'd0 && (state == CMD || state == WDATA))
                proto_error_n = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (stb_fall) begin
                        state_n   = CMD;
                        bit_cnt_n = '0;
                    end
                end
                CMD, WDATA: begin
                    if (bit_edge) begin
                        shift_n   = new_byte;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (state == WDATA) begin
                                disp_ram_n[{addr, 3'b000} +: 8] = new_byte;
                                if (!fixed)
                                    addr_n = addr + 4'd1;
                            end else begin
                                case (cmd_type_t'(new_byte[7:6]))
                                    CMD_DATA: begin
                                        fixed_n = new_byte[FIXED_BIT];
                                        if (new_byte[READ_BIT]) begin
                                            state_n    = RDATA;
                                            rd_shift_n = keys_in;
                                            rd_cnt_n   = '0;
                                        end else begin
                                            state_n = IGNORE;
                                        end
                                    end
                                    CMD_ADDR: begin
                                        addr_n  = new_byte[3:0];
                                        state_n = WDATA;
                                    end
                                    CMD_DISPLAY: begin
                                        display_on_n = new_byte[DISP_ON_BIT];
                                        brightness_n = new_byte[2:0];
                                        state_n      = IGNORE;
                                    end
                                    default: state_n = IGNORE;
                                endcase
                            end
                        end
                    end
                end
                RDATA: begin
                    if (drive_edge) begin
                        if (rd_cnt < 6'(KEY_BYTES * 8)) begin
                            dio_oe_n   = 1'b1;
                            dio_out_n  = rd_shift[0];
                            rd_shift_n = {1'b0, rd_shift[KEY_BYTES*8-1:1]};
                            rd_cnt_n   = rd_cnt + 6'd1;
                        end else begin
                            dio_oe_n = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            addr        <= '0;
            fixed       <= 1'b0;
            disp_ram    <= '0;
            display_on  <= 1'b0;
            brightness  <= '0;
            rd_shift    <= '0;
            rd_cnt      <= '0;
            tm_dio_out  <= 1'b1;
            tm_dio_oe   <= 1'b0;
            frame_done  <= 1'b0;
            proto_error <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            shift       <= shift_n;
            addr        <= addr_n;
            fixed       <= fixed_n;
            disp_ram    <= disp_ram_n;
            display_on  <= display_on_n;
            brightness  <= brightness_n;
            rd_shift    <= rd_shift_n;
            rd_cnt      <= rd_cnt_n;
            tm_dio_out  <= dio_out_n;
            tm_dio_oe   <= dio_oe_n;
            frame_done  <= frame_done_n;
            proto_error <= proto_error_n;
        end
    end

endmodule

// File: tb/tb_tm1638_responder.sv
// Self-checking bench: acts as the TM1638 host and compares against a byte-level model.
module tb_tm1638_responder;

    localparam int H = 6;  // host half-period in system clocks

    logic         clock = 1'b0;
    logic         reset;
    logic         tm_strobe, tm_clock, tm_dio_in;
    logic         tm_dio_out, tm_dio_oe;
    logic [31:0]  keys_in;
    logic [127:0] disp_ram;
    logic         display_on;
    logic [2:0]   brightness;
    logic         frame_done, proto_error;

    int vectors = 0;
    int miscompares = 0;
    int fd_cnt = 0, pe_cnt = 0;
    int exp_fd = 0, exp_pe = 0;

    logic [7:0] m_ram [16];
    logic [3:0] m_addr;
    logic       m_fixed, m_on;
    logic [2:0] m_bright;
    logic [7:0] frame_q [$];

    tm1638_responder #(.SYNC_STAGES(2)) dut (
        .clock(clock), .reset(reset),
        .tm_strobe(tm_strobe), .tm_clock(tm_clock), .tm_dio_in(tm_dio_in),
        .tm_dio_out(tm_dio_out), .tm_dio_oe(tm_dio_oe),
        .keys_in(keys_in), .disp_ram(disp_ram),
        .display_on(display_on), .brightness(brightness),
        .frame_done(frame_done), .proto_error(proto_error)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (frame_done === 1'b1) fd_cnt++;
        if (proto_error === 1'b1) pe_cnt++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int a = 0; a < 16; a++) m_ram[a] = 8'h00;
        m_addr = '0; m_fixed = 1'b0; m_on = 1'b0; m_bright = '0;
    endfunction

    function automatic void model_apply();
        logic [7:0] c;
        c = frame_q[0];
        case (c[7:6])
            2'b01: m_fixed = c[2];
            2'b10: begin m_on = c[3]; m_bright = c[2:0]; end
            2'b11: begin
                m_addr = c[3:0];
                for (int i = 1; i < frame_q.size(); i++) begin
                    m_ram[m_addr] = frame_q[i];
                    if (!m_fixed) m_addr = 4'((int'(m_addr) + 1) % 16);
                end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [127:0] model_ram();
        logic [127:0] v;
        for (int a = 0; a < 16; a++) v[a*8 +: 8] = m_ram[a];
        return v;
    endfunction

    // ---------------- host driver ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic stb_low();
        tm_strobe = 1'b0;
        wait_clk(H);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            tm_clock = 1'b0; tm_dio_in = b[i];
            wait_clk(H);
            tm_clock = 1'b1;
            wait_clk(H);
        end
    endtask

    task automatic stb_high();
        wait_clk(H);
        tm_strobe = 1'b1; tm_dio_in = 1'b1;
        wait_clk(H + 4);
        exp_fd++;
    endtask

    task automatic do_frame();
        stb_low();
        foreach (frame_q[i]) send_bits(frame_q[i], 8);
        stb_high();
        model_apply();
    endtask

    task automatic host_read(output logic [31:0] v, output logic oe_ok);
        v = '0; oe_ok = 1'b1;
        tm_dio_in = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tm_clock = 1'b0;
            wait_clk(H);
            v[i] = tm_dio_out;
            if (tm_dio_oe !== 1'b1) oe_ok = 1'b0;
            tm_clock = 1'b1;
            wait_clk(H);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; tm_strobe = 1'b1; tm_clock = 1'b1; tm_dio_in = 1'b1; keys_in = '0;
        model_reset();
        wait_clk(3);
        vectors++;
        if (disp_ram !== '0) begin miscompares++;
            $display("FAIL reset_disp_ram: got %h expected %h", disp_ram, 128'h0); end
        vectors++;
        if ({display_on, brightness} !== 4'h0) begin miscompares++;
            $display("FAIL reset_display: got on=%b br=%0d expected on=0 br=0", display_on, brightness); end
        vectors++;
        if ({tm_dio_out, tm_dio_oe} !== 2'b10) begin miscompares++;
            $display("FAIL reset_dio: got out=%b oe=%b expected out=1 oe=0", tm_dio_out, tm_dio_oe); end
        vectors++;
        if ({frame_done, proto_error} !== 2'b00) begin miscompares++;
            $display("FAIL reset_pulses: got fd=%b pe=%b expected 0 0", frame_done, proto_error); end
        reset = 1'b1;
        wait_clk(6);
        vectors++;
        if (fd_cnt !== 0 || pe_cnt !== 0) begin miscompares++;
            $display("FAIL release_pulses: got fd=%0d pe=%0d expected 0 0", fd_cnt, pe_cnt); end
    endtask

    task automatic test_auto_increment();
        frame_q = '{8'h40}; do_frame();
        frame_q = '{8'hC0, 8'h3F, 8'h06, 8'h77}; do_frame();
        vectors++;
        if (disp_ram[23:0] !== 24'h77063F) begin miscompares++;
            $display("FAIL auto_inc_bytes: got %h expected %h", disp_ram[23:0], 24'h77063F); end
        frame_q = '{8'hCF, 8'h11, 8'h22}; do_frame();
        vectors++;
        if ({disp_ram[127:120], disp_ram[7:0]} !== 16'h1122) begin miscompares++;
            $display("FAIL auto_inc_wrap: got addr15=%h addr0=%h expected 11 22",
                     disp_ram[127:120], disp_ram[7:0]); end
        vectors++;
        if (disp_ram !== model_ram()) begin miscompares++;
            $display("FAIL auto_inc_ram: got %h expected %h", disp_ram, model_ram()); end
        vectors++;
        if (fd_cnt !== exp_fd) begin miscompares++;
            $display("FAIL auto_inc_frame_done: got %0d expected %0d", fd_cnt, exp_fd); end
    endtask

    task automatic test_fixed_address();
        frame_q = '{8'h44}; do_frame();
        frame_q = '{8'hC5, 8'hAA, 8'hBB}; do_frame();
        vectors++;
        if ({disp_ram[55:48], disp_ram[47:40]} !== 16'h00BB) begin miscompares++;
            $display("FAIL fixed_addr: got addr6=%h addr5=%h expected 00 BB",
                     disp_ram[55:48], disp_ram[47:40]); end
        vectors++;
        if (disp_ram !== model_ram()) begin miscompares++;
            $display("FAIL fixed_ram: got %h expected %h", disp_ram, model_ram()); end
    endtask

    task automatic test_display_control();
        int fd0;
        fd0 = fd_cnt;
        frame_q = '{8'h8F}; do_frame();
        vectors++;
        if ({display_on, brightness} !== 4'b1_111) begin miscompares++;
            $display("FAIL display_8f: got on=%b br=%0d expected on=1 br=7", display_on, brightness); end
        frame_q = '{8'h80}; do_frame();
        vectors++;
        if ({display_on, brightness} !== 4'b0_000) begin miscompares++;
            $display("FAIL display_80: got on=%b br=%0d expected on=0 br=0", display_on, brightness); end
        vectors++;
        if (fd_cnt - fd0 !== 2) begin miscompares++;
            $display("FAIL display_frame_done: got %0d pulses expected 2", fd_cnt - fd0); end
    endtask

    task automatic test_key_read();
        logic [31:0] v, k;
        logic        oe_ok;
        keys_in = 32'h04104001;
        stb_low();
        send_bits(8'h42, 8);
        frame_q = '{8'h42}; model_apply();
        keys_in = $urandom();  // changes after the command must not reach the host
        host_read(v, oe_ok);
        vectors++;
        if (v !== 32'h04104001) begin miscompares++;
            $display("FAIL key_read_data: got %h expected %h", v, 32'h04104001); end
        vectors++;
        if (oe_ok !== 1'b1) begin miscompares++;
            $display("FAIL key_read_oe_during: got oe dropped expected oe=1 on all 32 bits"); end
        tm_clock = 1'b0;
        wait_clk(H);
        vectors++;
        if (tm_dio_oe !== 1'b0) begin miscompares++;
            $display("FAIL key_read_oe_33rd: got oe=%b expected 0", tm_dio_oe); end
        tm_clock = 1'b1;
        wait_clk(H);
        stb_high();

        k = $urandom();
        keys_in = k;
        stb_low();
        send_bits(8'h42, 8);
        host_read(v, oe_ok);
        vectors++;
        if (v !== k || tm_dio_oe !== 1'b1) begin miscompares++;
            $display("FAIL key_read2: got data=%h oe=%b expected data=%h oe=1", v, tm_dio_oe, k); end
        stb_high();
        vectors++;
        if ({tm_dio_out, tm_dio_oe} !== 2'b10) begin miscompares++;
            $display("FAIL key_read_stb_rise: got out=%b oe=%b expected out=1 oe=0", tm_dio_out, tm_dio_oe); end
    endtask

    task automatic test_partial_byte();
        stb_low();
        send_bits(8'hC2, 8);
        send_bits(8'h12, 8);
        send_bits(8'h99, 5);
        stb_high();
        exp_pe++;
        frame_q = '{8'hC2, 8'h12}; model_apply();
        vectors++;
        if (disp_ram !== model_ram()) begin miscompares++;
            $display("FAIL partial_ram: got %h expected %h", disp_ram, model_ram()); end
        vectors++;
        if (pe_cnt !== exp_pe) begin miscompares++;
            $display("FAIL partial_proto_error: got %0d expected %0d", pe_cnt, exp_pe); end
        stb_low();
        send_bits(8'hC7, 3);
        stb_high();
        exp_pe++;
        frame_q = '{8'hC3, 8'h5A}; do_frame();
        vectors++;
        if (pe_cnt !== exp_pe || disp_ram !== model_ram()) begin miscompares++;
            $display("FAIL partial_cmd: got pe=%0d ram=%h expected pe=%0d ram=%h",
                     pe_cnt, disp_ram, exp_pe, model_ram()); end
    endtask

    task automatic test_random();
        logic [31:0] v, k;
        logic        oe_ok;
        logic [7:0]  c;
        int          kind, n;
        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 4);
            c = 8'($urandom());
            case (kind)
                0: frame_q = '{{2'b01, c[5:3], c[2], 2'b00}};
                1: frame_q = '{{2'b11, c[5:0]}};
                2: frame_q = '{{2'b10, c[5:0]}};
                3: frame_q = '{{2'b00, c[5:0]}};
                default: frame_q = '{{2'b01, c[5:3], c[2], 2'b10}};
            endcase
            if (kind < 4) begin
                n = $urandom_range(kind == 1 ? 1 : 0, 5);
                for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom()));
                do_frame();
            end else begin
                k = $urandom();
                keys_in = k;
                stb_low();
                send_bits(frame_q[0], 8);
                model_apply();
                host_read(v, oe_ok);
                vectors++;
                if (v !== k || oe_ok !== 1'b1) begin miscompares++;
                    $display("FAIL rand_read it=%0d: got data=%h oe_ok=%b expected data=%h oe_ok=1",
                             it, v, oe_ok, k); end
                send_bits(8'hFF, $urandom_range(0, 2));
                stb_high();
            end
            vectors++;
            if (disp_ram !== model_ram() || display_on !== m_on || brightness !== m_bright) begin
                miscompares++;
                $display("FAIL rand_state it=%0d: got ram=%h on=%b br=%0d expected ram=%h on=%b br=%0d",
                         it, disp_ram, display_on, brightness, model_ram(), m_on, m_bright);
            end
        end
        vectors++;
        if (fd_cnt !== exp_fd || pe_cnt !== exp_pe) begin miscompares++;
            $display("FAIL rand_pulses: got fd=%0d pe=%0d expected fd=%0d pe=%0d",
                     fd_cnt, pe_cnt, exp_fd, exp_pe); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] v;
        frame_q = '{8'h8D}; do_frame();
        frame_q = '{8'h44}; do_frame();
        frame_q = '{8'hC9, 8'hE7}; do_frame();
        stb_low();
        send_bits(8'hC3, 8);
        send_bits(8'h55, 4);
        reset = 1'b0;
        #1;
        vectors++;
        if (disp_ram !== '0 || display_on !== 1'b0 || brightness !== 3'd0) begin miscompares++;
            $display("FAIL midreset_state: got ram=%h on=%b br=%0d expected all zero",
                     disp_ram, display_on, brightness); end
        vectors++;
        if ({tm_dio_out, tm_dio_oe} !== 2'b10) begin miscompares++;
            $display("FAIL midreset_dio: got out=%b oe=%b expected out=1 oe=0", tm_dio_out, tm_dio_oe); end
        tm_clock = 1'b1; tm_strobe = 1'b1;
        wait_clk(H);
        reset = 1'b1;
        model_reset();
        wait_clk(H);

        stb_low();
        send_bits(8'h42, 8);
        keys_in = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            tm_clock = 1'b0; wait_clk(H); tm_clock = 1'b1; wait_clk(H);
        end
        tm_clock = 1'b0;
        wait_clk(H);
        v[0] = tm_dio_oe;
        reset = 1'b0;
        #1;
        vectors++;
        if ({v[0], tm_dio_oe, tm_dio_out} !== 3'b101) begin miscompares++;
            $display("FAIL midreset_read_oe: got before=%b after=%b out=%b expected 1 0 1",
                     v[0], tm_dio_oe, tm_dio_out); end
        tm_clock = 1'b1; tm_strobe = 1'b1;
        wait_clk(H);
        reset = 1'b1;
        model_reset();
        wait_clk(H);

        frame_q = '{8'hC0, 8'h3F, 8'h06}; do_frame();
        vectors++;
        if (disp_ram[7:0] !== 8'h3F) begin miscompares++;
            $display("FAIL midreset_next_frame: got %h expected %h", disp_ram[7:0], 8'h3F); end
        vectors++;
        if (disp_ram !== model_ram() || fd_cnt !== exp_fd || pe_cnt !== exp_pe) begin miscompares++;
            $display("FAIL midreset_after: got ram=%h fd=%0d pe=%0d expected ram=%h fd=%0d pe=%0d",
                     disp_ram, fd_cnt, pe_cnt, model_ram(), exp_fd, exp_pe); end
    endtask

    initial begin
        test_reset();
        test_auto_increment();
        test_fixed_address();
        test_display_control();
        test_key_read();
        test_partial_byte();
        test_random();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
